// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle path: the pulse-width word
// size used by both pwm_duty_ctrl and PWM, the sequencer state encoding,
// and the clamp applied to incoming targets.
package pwm_pkg;

  // Width of the PWM.PW pulse-width word.
  localparam int unsigned PWM_W = 12;

  // Sequencer states. OFF holds the output at zero and refuses targets,
  // IDLE sits on the target, and RAMP slews toward it once per frame.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RAMP = 2'd2
  } pwm_state_e;

  // Limit a requested pulse width to [lo, hi].
  function automatic int unsigned clamp_pw(input int unsigned value,
                                           input int unsigned lo,
                                           input int unsigned hi);
    int unsigned result;
    result = value;
    if (result < lo) result = lo;
    if (result > hi) result = hi;
    return result;
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter. It counts 0 .. FRAME_CYCLES-1 and wraps,
// raising frame_tick for the single cycle in which the count is at its
// last value. Blocks that need frame alignment act on the edge that
// ends a tick cycle.
module pwm_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  // A one-cycle frame still needs a one-bit counter.
  localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: wrap to zero after the last cycle of the frame.
  // NOTE: combinational blocks assign a default first so that every path
  // drives the output and no latch is inferred.
  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == LAST) count_d = '0;
  end

  // Counter register; restarts from zero on reset.
  // NOTE: flops use non-blocking assignments so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign frame_tick = (count_q == LAST);

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle sequencer feeding PWM.PW. Targets arrive over a valid/ready
// handshake and are clamped to [PW_MIN, PW_MAX]. Once per frame the
// output slews toward the target by at most `step` (0 = jump straight
// there). Dropping enable forces the output and the target to zero on
// the next edge, independent of the frame timing.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned W            = PWM_W,
  parameter int unsigned FRAME_CYCLES = 4096,
  parameter int unsigned PW_MIN       = 0,
  parameter int unsigned PW_MAX       = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_pw,
  input  logic [W-1:0] step,
  output logic [W-1:0] PW,
  output logic         frame_tick,
  output logic         busy,
  output logic         at_target
);

  pwm_state_e   state_q, state_d;
  logic [W-1:0] pw_q, pw_d;
  logic [W-1:0] target_q, target_d;

  logic [W-1:0] tgt_clamped;
  logic [W-1:0] ramp_next;
  logic         handshake;

  // Frame alignment comes from the shared timer; it runs regardless of
  // enable so the frame phase is never disturbed by gating.
  pwm_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick)
  );

  assign tgt_clamped = W'(clamp_pw(32'(tgt_pw), PW_MIN, PW_MAX));
  assign handshake   = tgt_valid && tgt_ready;

  // One frame's worth of slew toward the registered target. The extra
  // top bit keeps PW+step from wrapping before it is compared with the
  // target.
  always_comb begin
    logic [W:0] pw_ext;
    logic [W:0] tgt_ext;
    logic [W:0] step_ext;
    logic [W:0] sum;
    logic [W:0] diff;

    pw_ext    = {1'b0, pw_q};
    tgt_ext   = {1'b0, target_q};
    step_ext  = {1'b0, step};
    sum       = pw_ext + step_ext;
    diff      = pw_ext - tgt_ext;
    ramp_next = target_q;

    if (step == '0 || pw_q == target_q) begin
      ramp_next = target_q;
    end else if (target_q > pw_q) begin
      // Rising: stop at the target rather than overshoot it.
      ramp_next = (sum >= tgt_ext) ? target_q : sum[W-1:0];
    end else begin
      // Falling: only subtract when a full step still lands above target.
      ramp_next = (diff <= step_ext) ? target_q : (pw_q - step);
    end
  end

  // Next-state, target and output-word logic. Disable overrides
  // everything, including a handshake offered in the same cycle.
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    target_d = target_q;

    if (!enable) begin
      state_d  = ST_OFF;
      pw_d     = '0;
      target_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (target_q != pw_q) state_d = ST_RAMP;
        end
        ST_RAMP: begin
          if (target_q == pw_q) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase

      if (state_q == ST_IDLE || state_q == ST_RAMP) begin
        // The tick slews against the target held before this edge; a
        // target accepted on the same edge takes effect from the next tick.
        if (frame_tick) pw_d = ramp_next;
        if (handshake)  target_d = tgt_clamped;
      end
    end
  end

  // State, output word and target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      pw_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      target_q <= target_d;
    end
  end

  assign PW        = pw_q;
  assign tgt_ready = (state_q != ST_OFF);
  assign busy      = (state_q == ST_RAMP);
  assign at_target = (pw_q == target_q);

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Duty-cycle sequencer between the fuzzy-inference output stage and the `PWM` generator. It accepts target pulse widths over a valid/ready handshake and clamps them to a legal range. It drives the 12-bit `PW` input of `PWM`, slewing it toward the target by a programmable step once per frame, so the motor or actuator never sees a step change larger than `step`. Enable is a hard gate: disabling forces `PW` to 0 immediately.

## Interface
Parameters:
- `W` — 12 — pulse-width word width; matches `PWM.PW`.
- `FRAME_CYCLES` — 4096 — clocks per update frame; nominally one PWM period.
- `PW_MIN` — 0 — lower clamp for accepted targets.
- `PW_MAX` — 4095 — upper clamp for accepted targets.

Ports:
- `clk` — in — 1 — single system clock; all logic on the rising edge.
- `rst` — in — 1 — asynchronous, active-high reset.
- `enable` — in — 1 — level; 0 forces the OFF state.
- `tgt_valid` — in — 1 — a target pulse width is offered.
- `tgt_ready` — out — 1 — the block can accept a target.
- `tgt_pw` — in — W — requested pulse width.
- `step` — in — W — maximum change in `PW` per frame; 0 means jump to the target at the next frame.
- `PW` — out — W — pulse width driven to `PWM.PW`.
- `frame_tick` — out — 1 — one-cycle pulse on the last cycle of each frame.
- `busy` — out — 1 — high while in the RAMP state.
- `at_target` — out — 1 — high when `PW` equals the target register.

## Operation
- **Frame counter:** free-running from 0 to FRAME_CYCLES−1, then wraps to 0; it runs regardless of `enable`. `frame_tick` is high when the count equals FRAME_CYCLES−1.
- **Target register:** updated on a handshake (`tgt_valid && tgt_ready`) with `clamp(tgt_pw, PW_MIN, PW_MAX)`. Re-targeting during a ramp is allowed; the ramp then continues from the current `PW`.
- **States:**
  - OFF: `tgt_ready`=0, `PW`=0, target=0. Go to IDLE when `enable`=1.
  - IDLE: `tgt_ready`=1 and `PW`==target. Go to RAMP when the target register differs from `PW`.
  - RAMP: `tgt_ready`=1. On each `frame_tick`, `PW` moves toward the target. Go to IDLE once `PW`==target.
  - Any state: `enable`=0 → OFF. On the next edge `PW` becomes 0 and target becomes 0, independent of `frame_tick`.
- **Ramp arithmetic:** compute in W+1 bits, with no wrap.
  - Rising: `PW` ← min(`PW`+`step`, target).
  - Falling: `PW` ← max(`PW`−`step`, target), computed as target when `PW`−target ≤ `step`.
  - `step`=0: `PW` ← target.
- **Step sampling:** `step` is sampled on the tick edge itself.
- **Outputs:** `busy` = (state==RAMP). `at_target` = (`PW`==target), combinational from registers.

## Timing
- **Reset values:** `PW`=0, target=0, counter=0, state OFF, `tgt_ready`=0, `frame_tick`=0, `busy`=0, `at_target`=1.
- **Handshake to RAMP:** a target accepted on edge N puts the block in RAMP from N+1. Its first `PW` change occurs on the edge where `frame_tick`=1.
- **Update latency:** `PW` changes only on `frame_tick` edges, or on the edge after `enable` falls.
- **Simultaneous handshake and tick:** the tick uses the old target. The new target applies from the next tick.
- **Simultaneous `enable` fall and handshake:** OFF wins and the request is dropped. `tgt_ready` is already 0 by the following cycle.
- **Reset mid-ramp:** all registers return to their reset values asynchronously, and the counter restarts at 0.
- **Clamped target equal to `PW`:** IDLE is kept and `busy` never asserts.

## Structure
- **Package `pwm_pkg`:** holds `W`, the state enum (OFF/IDLE/RAMP), and the clamp function. The same package is shared with `PWM` for the width.
- **Sub-module `pwm_frame_timer`:** the counter plus the `frame_tick` generator (parameter FRAME_CYCLES). Reused by any future block that needs frame alignment.
- **Top-level wiring:** `pwm_duty_ctrl.PW` connects directly to `PWM.PW`.

## Test plan
All scenarios use FRAME_CYCLES=8.
- **Reset and enable:** assert `rst`, then release with `enable`=1 → `PW`=0, `tgt_ready`=1 one cycle after `enable`, `at_target`=1, `busy`=0.
- **Ramp up:** `step`=100, accept target 250 → `PW` takes 100, 200, 250 on three consecutive ticks, and `busy` falls the cycle after 250.
- **Clamp and jump:** PW_MAX=4000, `step`=0, offer 4095 → `PW`=4000 at the first tick, then IDLE.
- **Re-target mid-ramp:** `PW` at 200 rising toward 1000 with `step`=100, offer 150 → next tick gives `PW`=150, then IDLE.
- **Handshake on the tick cycle:** `PW` at 200 rising toward 1000 with `step`=100; accept target 300 on the `frame_tick` cycle → that tick yields 300 (the old target's step). The next tick yields 300 again, and the block goes to IDLE.
- **Disable and reset mid-ramp:** deassert `enable` mid-ramp → `PW`=0 on the next edge, `tgt_ready`=0, and no change on later ticks. Asserting `rst` mid-ramp restores all reset values immediately.
